ft_tx_arbiter: RTL and testbench

- Shares the single sync245 transmit byte stream between NCH independent source channels (level-reporting FIFOs).
- Each grant is sent as one framed packet: a header byte, then 1..MAXBURST payload bytes.
- Channels are served round-robin, so no channel can starve another.
- Sits in the ft_clkout domain, between the channel FIFOs and the tx_data/tx_avail/tx_pull side of sync245.

---
 rtl/ft_tx_arbiter_pkg.sv | 18 +
 rtl/ft_tx_arbiter_if.sv | 11 +
 rtl/ft_tx_arbiter_rr_pick.sv | 24 ++
 rtl/ft_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_ft_tx_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_tx_arbiter_pkg.sv
// Shared types and header field layout for the sync245 transmit arbiter.
package ft_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_e;

    // Header byte layout: {chan[1:0], len-1[5:0]}
    localparam int HDR_CHAN_MSB = 7;
    localparam int HDR_CHAN_LSB = 6;
    localparam int HDR_LEN_MSB  = 5;
    localparam int HDR_LEN_LSB  = 0;

    localparam int MAXBURST_LIMIT = 64;

endpackage

// File: rtl/ft_tx_arbiter_if.sv
// Byte stream between the arbiter (master) and the sync245 transmit side (slave).
interface ft_tx_arbiter_if;

    logic [7:0] tx_data;
    logic       tx_avail;
    logic       tx_pull;

    modport master (output tx_data, output tx_avail, input tx_pull);
    modport slave  (input tx_data, input tx_avail, output tx_pull);

endinterface

// File: rtl/ft_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of eligible at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] eligible,
    input  logic [1:0]     rr_ptr,
    output logic           found,
    output logic [1:0]     index
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        found = 1'b0;
        index = 2'd0;
        // Walk from the farthest offset down so the nearest eligible channel is written last and wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (eligible[(int'(rr_ptr) + k) % NCH]) begin
                found = 1'b1;
                index = 2'((int'(rr_ptr) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Round-robin packetiser sharing the sync245 transmit stream between NCH channel FIFOs.
module ft_tx_arbiter
    import ft_arb_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int MAXBURST = 16,
    parameter int LVLW     = 7
) (
    input  logic                ft_clkout,
    input  logic                rst_n,
    input  logic [NCH*LVLW-1:0] ch_level,
    input  logic [NCH-1:0]      ch_enable,
    input  logic [NCH*8-1:0]    ch_data,
    output logic [NCH-1:0]      ch_pull,
    ft_tx_arbiter_if.master     tx,
    output logic [1:0]          grant_chan,
    output logic                busy
);

    localparam int BURST = (MAXBURST > MAXBURST_LIMIT) ? MAXBURST_LIMIT : MAXBURST;

    arb_state_e state_q;
    logic [1:0] rr_ptr_q;
    logic [1:0] chan_q;
    logic [6:0] len_q;
    logic [6:0] remaining_q;
    logic [7:0] hdr_q;

    logic [LVLW-1:0] lvl_arr  [NCH];
    logic [7:0]      data_arr [NCH];
    logic [NCH-1:0]  eligible;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign lvl_arr[i]  = ch_level[i*LVLW +: LVLW];
        assign data_arr[i] = ch_data[i*8 +: 8];
        assign eligible[i] = ch_enable[i] && (lvl_arr[i] != '0);
    end

    logic       pick_found;
    logic [1:0] pick_idx;

    rr_pick #(.NCH(NCH)) u_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .found    (pick_found),
        .index    (pick_idx)
    );

    logic [LVLW-1:0] pick_lvl;
    logic [6:0]      len_next;
    logic [7:0]      hdr_next;
    logic [1:0]      rr_next;

    assign pick_lvl = lvl_arr[pick_idx];
    assign rr_next  = 2'((int'(chan_q) + 1) % NCH);

    always_comb begin
        len_next = (int'(pick_lvl) > BURST) ? 7'(BURST) : 7'(pick_lvl);
        hdr_next = '0;
        hdr_next[HDR_CHAN_MSB:HDR_CHAN_LSB] = pick_idx;
        hdr_next[HDR_LEN_MSB:HDR_LEN_LSB]   = 6'(len_next - 7'd1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ft_clkout or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            chan_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            hdr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Level and enable are latched here only; later changes wait for the next packet.
                    if (pick_found) begin
                        chan_q  <= pick_idx;
                        len_q   <= len_next;
                        hdr_q   <= hdr_next;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (tx.tx_pull) begin
                        remaining_q <= len_q;
                        state_q     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (tx.tx_pull) begin
                        remaining_q <= remaining_q - 7'd1;
                        if (remaining_q == 7'd1) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= rr_next;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // tx_avail/tx_data depend only on state and ch_data, keeping tx_pull out of their cone.
    logic [7:0] tx_data_c;

    always_comb begin
        tx_data_c = 8'h00;
        ch_pull   = '0;
        case (state_q)
            HDR:     tx_data_c = hdr_q;
            PAYLOAD: begin
                tx_data_c       = data_arr[chan_q];
                ch_pull[chan_q] = tx.tx_pull;
            end
            default: tx_data_c = 8'h00;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign tx.tx_avail = busy;
    assign tx.tx_data  = tx_data_c;
    assign grant_chan  = chan_q;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter: FIFO models feed channels, expected bytes are queued per packet.
module tb_ft_tx_arbiter;

    localparam int NCH      = 4;
    localparam int MAXBURST = 16;
    localparam int LVLW     = 7;

    logic                ft_clkout = 1'b0;
    logic                rst_n     = 1'b0;
    logic [NCH*LVLW-1:0] ch_level;
    logic [NCH-1:0]      ch_enable;
    logic [NCH*8-1:0]    ch_data;
    logic [NCH-1:0]      ch_pull;
    logic [1:0]          grant_chan;
    logic                busy;

    ft_tx_arbiter_if tx_if ();

    ft_tx_arbiter #(.NCH(NCH), .MAXBURST(MAXBURST), .LVLW(LVLW)) dut (
        .ft_clkout  (ft_clkout),
        .rst_n      (rst_n),
        .ch_level   (ch_level),
        .ch_enable  (ch_enable),
        .ch_data    (ch_data),
        .ch_pull    (ch_pull),
        .tx         (tx_if),
        .grant_chan (grant_chan),
        .busy       (busy)
    );

    always #8 ft_clkout = ~ft_clkout;

    typedef struct {
        logic [7:0] data;
        bit         payload;
        int         ch;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] mem [NCH][128];
    int         rd_ptr [NCH];
    int         wr_ptr [NCH];
    int         exp_ptr [NCH];
    int         pulls_cnt [NCH];
    int         total = 0;
    int         bad   = 0;
    int         xfers = 0;

    task automatic update_inputs();
        for (int i = 0; i < NCH; i++) begin
            int lvl;
            lvl = wr_ptr[i] - rd_ptr[i];
            if (lvl > 127) lvl = 127;
            ch_level[i*LVLW +: LVLW] = LVLW'(lvl);
            ch_data[i*8 +: 8] = (lvl > 0) ? mem[i][rd_ptr[i] % 128] : 8'h00;
        end
    endtask

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_ptr[ch] % 128] = 8'((ch << 6) ^ (wr_ptr[ch] * 7 + 3));
            wr_ptr[ch]++;
        end
        update_inputs();
    endtask

    task automatic expect_packet(input int ch, input int len, input logic [7:0] hdr);
        exp_t e;
        e.data = hdr; e.payload = 1'b0; e.ch = ch;
        exp_q.push_back(e);
        for (int k = 0; k < len; k++) begin
            e.data = mem[ch][exp_ptr[ch] % 128]; e.payload = 1'b1; e.ch = ch;
            exp_q.push_back(e);
            exp_ptr[ch]++;
        end
    endtask

    // One clock: monitor at negedge, then apply FIFO pops just after the rising edge.
    task automatic cycle();
        logic [NCH-1:0] pend_pull;
        logic [NCH-1:0] want_pull;
        exp_t           e;
        @(negedge ft_clkout);
        if (tx_if.tx_avail && tx_if.tx_pull) begin
            xfers++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got tx_data=%h, required no transfer", tx_if.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_if.tx_data !== e.data) begin
                    bad++;
                    $display("FAIL tx_data: got %h, required %h (ch%0d payload=%0d)", tx_if.tx_data, e.data, e.ch, e.payload);
                end
                want_pull = '0;
                if (e.payload) want_pull[e.ch] = 1'b1;
                total++;
                if (ch_pull !== want_pull) begin
                    bad++;
                    $display("FAIL ch_pull_xfer: got %b, required %b", ch_pull, want_pull);
                end
            end
        end else begin
            total++;
            if (ch_pull !== '0) begin
                bad++;
                $display("FAIL ch_pull_idle: got %b, required 0", ch_pull);
            end
        end
        pend_pull = ch_pull;
        @(posedge ft_clkout);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (pend_pull[i]) begin
                rd_ptr[i]++;
                pulls_cnt[i]++;
            end
        end
        update_inputs();
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !busy) && n < budget) begin
            cycle();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || busy) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bytes outstanding busy=%b, required 0 and 0", name, exp_q.size(), busy);
        end
    endtask

    task automatic run_until_xfers(input int target, input string name);
        int n = 0;
        while (xfers < target && n < 200) begin
            cycle();
            n++;
        end
        total++;
        if (xfers < target) begin
            bad++;
            $display("FAIL %s_progress: got %0d transfers, required %0d", name, xfers, target);
        end
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        tx_if.tx_pull  = 1'b0;
        ch_enable      = '1;
        for (int i = 0; i < NCH; i++) begin
            rd_ptr[i] = 0; wr_ptr[i] = 0; exp_ptr[i] = 0; pulls_cnt[i] = 0;
        end
        exp_q.delete();
        update_inputs();
        cycle();
        cycle();
        rst_n = 1'b1;
        xfers = 0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        ch_enable     = '1;
        tx_if.tx_pull = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            rd_ptr[i] = 0; wr_ptr[i] = 0; exp_ptr[i] = 0; pulls_cnt[i] = 0;
        end
        load(0, 3);
        #1;
        total++; if (tx_if.tx_avail !== 1'b0) begin bad++; $display("FAIL reset_tx_avail: got %b, required 0", tx_if.tx_avail); end
        total++; if (ch_pull !== '0)          begin bad++; $display("FAIL reset_ch_pull: got %b, required 0", ch_pull); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
        total++; if (tx_if.tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h, required 00", tx_if.tx_data); end
        total++; if (grant_chan !== 2'd0)     begin bad++; $display("FAIL reset_grant: got %0d, required 0", grant_chan); end
    endtask

    task automatic test_single();
        reset_dut();
        tx_if.tx_pull = 1'b1;
        load(0, 3);
        expect_packet(0, 3, 8'h02);
        drain(50, "single");
        total++; if (pulls_cnt[0] != 3)       begin bad++; $display("FAIL single_pulls: got %0d, required 3", pulls_cnt[0]); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL single_busy: got %b, required 0", busy); end
        total++; if (tx_if.tx_avail !== 1'b0) begin bad++; $display("FAIL single_avail: got %b, required 0", tx_if.tx_avail); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        tx_if.tx_pull = 1'b1;
        load(0, 5); load(1, 5); load(3, 5);
        expect_packet(0, 5, 8'h04);
        expect_packet(1, 5, 8'h44);
        expect_packet(3, 5, 8'hC4);
        drain(100, "rr");
        total++; if (grant_chan !== 2'd3) begin bad++; $display("FAIL rr_grant_last: got %0d, required 3", grant_chan); end
        load(0, 2); load(1, 2);
        expect_packet(0, 2, 8'h01);
        expect_packet(1, 2, 8'h41);
        drain(50, "rr_refill");
        total++; if (grant_chan !== 2'd1) begin bad++; $display("FAIL rr_grant_refill: got %0d, required 1", grant_chan); end
    endtask

    task automatic test_clamp();
        reset_dut();
        tx_if.tx_pull = 1'b1;
        load(2, 40);
        expect_packet(2, 16, 8'h8F);
        expect_packet(2, 16, 8'h8F);
        expect_packet(2, 8, 8'h87);
        drain(200, "clamp");
        total++; if (pulls_cnt[2] != 40) begin bad++; $display("FAIL clamp_pulls: got %0d, required 40", pulls_cnt[2]); end
    endtask

    task automatic test_stall();
        logic [7:0] held;
        reset_dut();
        tx_if.tx_pull = 1'b1;
        load(1, 5);
        expect_packet(1, 5, 8'h44);
        run_until_xfers(3, "stall");
        tx_if.tx_pull = 1'b0;
        held = mem[1][rd_ptr[1] % 128];
        for (int c = 0; c < 10; c++) begin
            cycle();
            total++;
            if (tx_if.tx_data !== held || tx_if.tx_avail !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold: got data=%h avail=%b, required data=%h avail=1", tx_if.tx_data, tx_if.tx_avail, held);
            end
        end
        total++; if (pulls_cnt[1] != 2) begin bad++; $display("FAIL stall_pulls_mid: got %0d, required 2", pulls_cnt[1]); end
        tx_if.tx_pull = 1'b1;
        drain(50, "stall");
        total++; if (pulls_cnt[1] != 5) begin bad++; $display("FAIL stall_pulls_end: got %0d, required 5", pulls_cnt[1]); end
    endtask

    task automatic test_mask_late();
        reset_dut();
        ch_enable     = 4'b0010;
        tx_if.tx_pull = 1'b1;
        load(0, 4); load(1, 4); load(2, 4); load(3, 4);
        expect_packet(1, 4, 8'h43);
        run_until_xfers(2, "mask");
        load(1, 6);
        load(0, 5);
        expect_packet(1, 6, 8'h45);
        drain(100, "mask");
        total++; if (pulls_cnt[0] != 0 || pulls_cnt[2] != 0 || pulls_cnt[3] != 0) begin
            bad++;
            $display("FAIL mask_other_pulls: got %0d/%0d/%0d, required 0/0/0", pulls_cnt[0], pulls_cnt[2], pulls_cnt[3]);
        end
        total++; if (pulls_cnt[1] != 10) begin bad++; $display("FAIL mask_ch1_pulls: got %0d, required 10", pulls_cnt[1]); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        tx_if.tx_pull = 1'b1;
        load(0, 2); load(1, 5);
        expect_packet(0, 2, 8'h01);
        expect_packet(1, 5, 8'h44);
        run_until_xfers(6, "areset");
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_if.tx_avail !== 1'b0) begin bad++; $display("FAIL areset_avail: got %b, required 0", tx_if.tx_avail); end
        total++; if (ch_pull !== '0)          begin bad++; $display("FAIL areset_pull: got %b, required 0", ch_pull); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL areset_busy: got %b, required 0", busy); end
        exp_q.delete();
        exp_ptr[1] = rd_ptr[1];
        load(0, 3);
        cycle();
        cycle();
        rst_n = 1'b1;
        expect_packet(0, 3, 8'h02);
        expect_packet(1, 3, 8'h42);
        drain(100, "areset");
    endtask

    initial begin
        tx_if.tx_pull = 1'b0;
        ch_enable     = '0;
        ch_level      = '0;
        ch_data       = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_stall();
        test_mask_late();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
